// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode/funct constants and load-type encoding
package mips_defs;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_B    = 3'd2,
    LD_BU   = 3'd3,
    LD_H    = 3'd4,
    LD_HU   = 3'd5
  } load_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - byte/halfword lane extraction, extension and alignment check
module load_extend
  import mips_defs::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  a_i,
  input  load_t       type_i,
  output logic [31:0] result_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lane out of the little-endian word
  always_comb begin
    byte_sel = word_i[7:0];
    case (a_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = a_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extend according to load type; flag addresses the memory cannot serve in one word
  always_comb begin
    result_o     = word_i;
    misaligned_o = 1'b0;
    case (type_i)
      LD_W: begin
        result_o     = word_i;
        misaligned_o = (a_i != 2'd0);
      end
      LD_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: result_o = {24'd0, byte_sel};
      LD_H: begin
        result_o     = {{16{half_sel[15]}}, half_sel};
        misaligned_o = a_i[0];
      end
      LD_HU: begin
        result_o     = {16'd0, half_sel};
        misaligned_o = a_i[0];
      end
      default: begin
        result_o     = word_i;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, destination decode and register-file writeback
module mem_wb_stage
  import mips_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic [31:0]       m_instr,
  input  logic [DATA_W-1:0] m_pc_add_8,
  input  logic [DATA_W-1:0] m_alu_result,
  input  logic [DATA_W-1:0] m_dm_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       w_instr,
  output logic              w_valid,
  output logic              load_misaligned,
  output logic [CNT_W-1:0]  retire_count
);

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] pc8_q, pc8_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state: flush beats stall, stall holds, otherwise capture or insert a bubble
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc8_d   = pc8_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = 32'd0;
    end else if (!stall) begin
      if (m_valid) begin
        valid_d = 1'b1;
        instr_d = m_instr;
        pc8_d   = m_pc_add_8;
        alu_d   = m_alu_result;
        rdata_d = m_dm_rdata;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        valid_d = 1'b0;
        instr_d = 32'd0;
      end
    end
  end

  // Stage register with asynchronous clear to a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      pc8_q   <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [5:0]  op, funct;
  logic        has_dest, use_pc8;
  logic [4:0]  dest;
  load_t       ld_type;
  logic [31:0] ld_data;
  logic        ld_mis;

  assign op    = instr_q[31:26];
  assign funct = instr_q[5:0];

  // Decode destination register, load type and link-value selection
  always_comb begin
    has_dest = 1'b0;
    dest     = 5'd0;
    ld_type  = LD_NONE;
    use_pc8  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU, F_ADD, F_SUBU, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            has_dest = 1'b1;
            dest     = instr_q[15:11];
          end
          F_JALR: begin
            has_dest = 1'b1;
            dest     = instr_q[15:11];
            use_pc8  = 1'b1;
          end
          default: has_dest = 1'b0;
        endcase
      end
      OP_ORI, OP_XORI, OP_ANDI, OP_SLTI, OP_SLTIU, OP_ADDI, OP_ADDIU, OP_LUI: begin
        has_dest = 1'b1;
        dest     = instr_q[20:16];
      end
      OP_LW:  begin has_dest = 1'b1; dest = instr_q[20:16]; ld_type = LD_W;  end
      OP_LB:  begin has_dest = 1'b1; dest = instr_q[20:16]; ld_type = LD_B;  end
      OP_LBU: begin has_dest = 1'b1; dest = instr_q[20:16]; ld_type = LD_BU; end
      OP_LH:  begin has_dest = 1'b1; dest = instr_q[20:16]; ld_type = LD_H;  end
      OP_LHU: begin has_dest = 1'b1; dest = instr_q[20:16]; ld_type = LD_HU; end
      OP_JAL: begin
        has_dest = 1'b1;
        dest     = REG_RA;
        use_pc8  = 1'b1;
      end
      default: has_dest = 1'b0;
    endcase
  end

  load_extend u_load_extend (
    .word_i       (rdata_q),
    .a_i          (alu_q[1:0]),
    .type_i       (ld_type),
    .result_o     (ld_data),
    .misaligned_o (ld_mis)
  );

  // Writeback port: address and data forced to zero whenever no write happens
  always_comb begin
    load_misaligned = valid_q & ld_mis;
    rf_we           = valid_q & has_dest & (dest != 5'd0) & ~load_misaligned;
    rf_waddr        = 5'd0;
    rf_wdata        = '0;
    if (rf_we) begin
      rf_waddr = dest;
      if (ld_type != LD_NONE) rf_wdata = ld_data;
      else if (use_pc8)       rf_wdata = pc8_q;
      else                    rf_wdata = alu_q;
    end
  end

  assign w_instr      = instr_q;
  assign w_valid      = valid_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, m_valid;
  logic [31:0] m_instr, m_pc_add_8, m_alu_result, m_dm_rdata;
  logic        rf_we, w_valid, load_misaligned;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, w_instr;
  logic [3:0]  retire_count;

  int checks = 0;
  int errors = 0;

  // expected contents of the WB stage
  logic        ev;
  logic [31:0] ei, epc, ealu, erd;
  int          ecnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_instr(m_instr), .m_pc_add_8(m_pc_add_8),
    .m_alu_result(m_alu_result), .m_dm_rdata(m_dm_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .w_instr(w_instr), .w_valid(w_valid), .load_misaligned(load_misaligned),
    .retire_count(retire_count)
  );

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the register file should see for a given WB content
  task automatic model(output logic we, output logic [31:0] waddr, output logic [31:0] wdata,
                       output logic mis);
    int op, fn, a, dst;
    logic has;
    logic [31:0] data, lane;
    op = int'(ei[31:26]);
    fn = int'(ei[5:0]);
    a  = int'(ealu[1:0]);
    has = 1'b0;
    dst = 0;
    mis = ev && ((op == 35 && a != 0) || ((op == 33 || op == 37) && (a % 2 == 1)));
    if (op == 0) begin
      if (fn inside {0, 2, 3, 4, 6, 7, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43}) begin
        has = 1'b1;
        dst = int'(ei[15:11]);
      end
    end else if (op inside {[8:15], 32, 33, 35, 36, 37}) begin
      has = 1'b1;
      dst = int'(ei[20:16]);
    end else if (op == 3) begin
      has = 1'b1;
      dst = 31;
    end
    data = ealu;
    if (op == 3 || (op == 0 && fn == 9)) data = epc;
    case (op)
      35: data = erd;
      32: begin lane = (erd >> (8 * a)) & 32'hFF;           data = (lane >= 128)   ? lane - 256   : lane; end
      36: begin lane = (erd >> (8 * a)) & 32'hFF;           data = lane; end
      33: begin lane = (erd >> (16 * (a / 2))) & 32'hFFFF;  data = (lane >= 32768) ? lane - 65536 : lane; end
      37: begin lane = (erd >> (16 * (a / 2))) & 32'hFFFF;  data = lane; end
      default: ;
    endcase
    we    = ev && has && dst != 0 && !mis;
    waddr = we ? dst : 0;
    wdata = we ? data : 0;
  endtask

  task automatic check_all(input string tag);
    logic we, mis;
    logic [31:0] wa, wd;
    model(we, wa, wd, mis);
    chk({tag, ".w_valid"}, 32'(w_valid), 32'(ev));
    chk({tag, ".w_instr"}, w_instr, ei);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), wa);
    chk({tag, ".rf_wdata"}, rf_wdata, wd);
    chk({tag, ".misaligned"}, 32'(load_misaligned), 32'(mis));
    chk({tag, ".retire"}, 32'(retire_count), 32'(ecnt));
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc8,
                      input logic [31:0] alu, input logic [31:0] rdat, input logic st, input logic fl);
    m_valid = v; m_instr = ins; m_pc_add_8 = pc8; m_alu_result = alu; m_dm_rdata = rdat;
    stall = st; flush = fl;
    @(posedge clk);
    #1;
    if (fl) begin
      ev = 1'b0; ei = 32'd0;
    end else if (!st) begin
      if (v) begin
        ev = 1'b1; ei = ins; epc = pc8; ealu = alu; erd = rdat;
        ecnt = (ecnt + 1) % 16;
      end else begin
        ev = 1'b0; ei = 32'd0;
      end
    end
    check_all(tag);
  endtask

  int ops[22] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 32, 33, 35, 36, 37, 40, 41, 43, 63};
  int fns[20] = '{0, 2, 3, 4, 6, 7, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 1, 63};

  initial begin
    logic [31:0] r, ins;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; m_valid = 1'b1;
    m_instr = mk_r(1, 2, 3, 33); m_pc_add_8 = 32'h8; m_alu_result = 32'h5; m_dm_rdata = 32'h0;
    ev = 1'b0; ei = 0; epc = 0; ealu = 0; erd = 0; ecnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // load extension
    step("lb", 1, mk_i(32, 1, 4, 3), 32'h3008, 32'h1003, 32'h80FF7F01, 0, 0);
    chk("lb.const", rf_wdata, 32'hFFFFFF80);
    chk("lb.rt", 32'(rf_waddr), 32'd4);
    step("lbu", 1, mk_i(36, 1, 5, 3), 32'h3008, 32'h1003, 32'h80FF7F01, 0, 0);
    chk("lbu.const", rf_wdata, 32'h00000080);
    step("lh", 1, mk_i(33, 1, 6, 2), 32'h3008, 32'h1002, 32'h80FF7F01, 0, 0);
    chk("lh.const", rf_wdata, 32'hFFFF80FF);
    chk("lh.nomis", 32'(load_misaligned), 32'd0);
    step("lhu", 1, mk_i(37, 1, 7, 0), 32'h3008, 32'h1000, 32'h80FF7F01, 0, 0);
    chk("lhu.const", rf_wdata, 32'h00007F01);

    // destination decode
    step("jal", 1, {6'd3, 26'h0000400}, 32'h3008, 32'h1234, 32'h0, 0, 0);
    chk("jal.waddr", 32'(rf_waddr), 32'd31);
    chk("jal.wdata", rf_wdata, 32'h3008);
    step("jalr", 1, mk_r(8, 0, 5, 9), 32'h4008, 32'h99, 32'h0, 0, 0);
    chk("jalr.waddr", 32'(rf_waddr), 32'd5);
    step("addu_r0", 1, mk_r(1, 2, 0, 33), 32'h0, 32'h77, 32'h0, 0, 0);
    chk("addu_r0.we", 32'(rf_we), 32'd0);
    step("sw", 1, mk_i(43, 1, 2, 4), 32'h0, 32'h1004, 32'h0, 0, 0);
    step("beq", 1, mk_i(4, 1, 2, 4), 32'h0, 32'h1, 32'h0, 0, 0);
    step("j", 1, {6'd2, 26'h100}, 32'h0, 32'h1, 32'h0, 0, 0);
    chk("j.we", 32'(rf_we), 32'd0);

    // misaligned loads
    step("lw_mis", 1, mk_i(35, 1, 8, 2), 32'h0, 32'h1002, 32'hDEADBEEF, 0, 0);
    chk("lw_mis.flag", 32'(load_misaligned), 32'd1);
    chk("lw_mis.we", 32'(rf_we), 32'd0);
    step("lhu_mis", 1, mk_i(37, 1, 8, 1), 32'h0, 32'h1001, 32'hDEADBEEF, 0, 0);
    chk("lhu_mis.flag", 32'(load_misaligned), 32'd1);

    // stall and flush
    step("addiu", 1, mk_i(9, 0, 3, 16), 32'h0, 32'h10, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 1, mk_r(1, 2, 9, 33), 32'h0, 32'hABCD, 32'h0, 1, 0);
    chk("stall.wdata", rf_wdata, 32'h10);
    chk("stall.waddr", 32'(rf_waddr), 32'd3);
    step("stall_flush", 1, mk_r(1, 2, 9, 33), 32'h0, 32'hABCD, 32'h0, 1, 1);
    chk("flush.valid", 32'(w_valid), 32'd0);

    // asynchronous reset while a load sits in WB
    step("lw_pre", 1, mk_i(35, 1, 10, 0), 32'h0, 32'h2000, 32'hCAFEF00D, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    ev = 1'b0; ei = 0; epc = 0; ealu = 0; erd = 0; ecnt = 0;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;

    // counter wrap with bubbles interleaved
    for (int i = 0; i < 17; i++) begin
      step("cnt", 1, mk_i(35, 1, 11, 0), 32'h0, 32'h2000 + 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
      if (i % 4 == 1) step("cnt_bub", 0, mk_r(1, 2, 3, 33), 32'h0, 32'h0, 32'h0, 0, 0);
    end
    chk("cnt.wrap", 32'(retire_count), 32'd1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      ins = {6'(ops[$urandom_range(21)]), r[25:6], 6'(fns[$urandom_range(19)])};
      step("rand", ($urandom_range(4) != 0), ins, $urandom(), $urandom(), $urandom(),
           ($urandom_range(5) == 0), ($urandom_range(9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage MIPS pipeline.
- Sits directly downstream of the memory level. It consumes the raw data-memory read word, ALU result, PC+8 and the instruction from memory.
- Performs load byte/halfword extraction and sign/zero extension, decodes the register-file destination and drives the register-file write port.
- Also exposes the stage's instruction and valid bit to the hazard/forwarding unit, and keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width. Fixed at 32 for MIPS; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold WB register contents
- flush  in  1  load a bubble into WB register
- m_valid  in  1  memory stage holds a real instruction
- m_instr  in  32  instruction in memory stage
- m_pc_add_8  in  32  link value for jal/jalr
- m_alu_result  in  32  ALU result / memory address
- m_dm_rdata  in  32  raw word read at {addr[31:2],2'b00}, little-endian byte lanes
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  destination register
- rf_wdata  out  32  write data
- w_instr  out  32  registered instruction (for forwarding)
- w_valid  out  1  WB holds a real instruction
- load_misaligned  out  1  registered load has an illegal alignment
- retire_count  out  CNT_W  instructions that entered WB

Behaviour:
- Reset (reset=0, asynchronous) clears the register stage to a bubble:
  - w_valid=0, w_instr=0, and the address, PC and data fields are 0.
  - retire_count=0, rf_we=0, rf_waddr=0, rf_wdata=0, load_misaligned=0.
- Register update, at each clk rising edge with reset=1, in priority order:
  1. flush=1: load a bubble (valid=0, instr=0). flush wins over stall.
  2. stall=1: hold all fields.
  3. Otherwise, if m_valid=0, load a bubble.
  4. Otherwise capture the m_* inputs and set valid=1.
- Latency: one cycle from the m_* inputs to rf_* outputs. The rf_* outputs are combinational from the registered fields.
- retire_count increments by 1 on each edge that captures a valid instruction (case 4 above). It wraps from 2^CNT_W-1 to 0 and is not affected by stall-hold cycles.
- Destination decode uses op = instr[31:26] and funct = instr[5:0]:
  - op=0 with funct in {addu, add, subu, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jalr}: rd = instr[15:11].
  - op=0 with funct=jr: no write.
  - ori, xori, andi, slti, sltiu, addi, addiu, lui, lw, lb, lbu, lh, lhu: rt = instr[20:16].
  - jal: 31.
  - Stores, branches, j, and undefined opcodes: no write.
- Data select:
  - Loads use the extracted memory data.
  - jal and jalr use pc_add_8.
  - All other instructions use alu_result.
- Load extraction, with a = alu_result[1:0]:
  - lw: the full word.
  - lb/lbu: byte lane a, sign-extended for lb and zero-extended for lbu.
  - lh/lhu: half lane a[1] (bits 15:0 when a[1]=0, bits 31:16 when a[1]=1), sign-extended for lh and zero-extended for lhu.
- load_misaligned=1 when valid=1 and either lw with a!=0, or lh/lhu with a[0]=1.
- rf_we = valid & has_dest & (waddr!=0) & !load_misaligned.
  - When rf_we=0, rf_waddr and rf_wdata are driven 0.
- A stall held across several cycles keeps rf_we asserted with the same values every cycle. The register file tolerates repeated identical writes.
- Reset asserted mid-operation discards the in-flight instruction. No write occurs in that cycle.

Decomposition:
- Shared package mips_defs holds:
  - Opcode constants (OP_RTYPE, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_JAL, the I-type ALU opcodes, stores, branches, j).
  - Funct constants (F_JR, F_JALR and the R-type ALU functs).
  - REG_RA=31.
- One natural sub-module: load_extend. It is purely combinational, with inputs word, a[1:0] and load type, and outputs the 32-bit result and the misaligned flag. The stage instantiates it once.

Test Plan:
- Extension: lb with word=0x80FF7F01 and a=3 -> rf_wdata=0xFFFFFF80, rf_waddr=rt, rf_we=1 one cycle after capture. lbu on the same word with a=3 -> 0x00000080. lh with a=2 -> 0xFFFF80FF. lhu with a=0 -> 0x00007F01.
- Destination decode:
  - jal -> rf_waddr=31, rf_wdata=m_pc_add_8 (e.g. 0x00003008).
  - jalr with rd=5 -> waddr=5.
  - addu with rd=0 -> rf_we=0.
  - sw, beq and j -> rf_we=0.
- Misaligned loads: lw with alu_result=0x1002 -> load_misaligned=1, rf_we=0. lhu with alu_result=0x1001 -> same. lh with 0x1002 -> no flag.
- Stall/flush:
  - Capture addiu $3 (=0x10).
  - Assert stall for 3 cycles -> outputs unchanged and retire_count stays +1.
  - Assert stall and flush together -> bubble next cycle, w_valid=0, rf_we=0.
- Counter: with CNT_W=4, feed 17 valid instructions -> retire_count=1 after wrap. Bubbles (m_valid=0) do not count.
- Async reset: pull reset low between clock edges while lw is in WB -> rf_we, w_valid and retire_count go 0 immediately. After release, the first valid capture writes normally.
